// File: rtl/multdiv_sequencer.sv
// Sequences one mult/div operation on the shared iterative unit for the X stage, then
// arbitrates the result (or an $r30 status code) onto the regfile write port.
module multdiv_sequencer #(
  parameter int unsigned Timeout = 40,
  parameter int unsigned MultExc = 4,
  parameter int unsigned DivExc  = 5
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic        req_is_div_i,
  input  logic [31:0] req_operand_a_i,
  input  logic [31:0] req_operand_b_i,
  input  logic [4:0]  req_rd_i,
  output logic        md_start_mult_o,
  output logic        md_start_div_o,
  output logic [31:0] md_operand_a_o,
  output logic [31:0] md_operand_b_o,
  input  logic        md_ready_i,
  input  logic        md_exception_i,
  input  logic [31:0] md_result_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_grant_i,
  output logic        busy_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [4:0]  StatusReg = 5'd30;

  typedef enum logic [1:0] {StIdle, StStart, StRun, StWb} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic              is_div_q, is_div_d;
  logic [31:0]       exc_code;
  logic              timed_out;

  assign exc_code  = is_div_q ? 32'(DivExc) : 32'(MultExc);
  assign timed_out = (cnt_q == CntW'(Timeout - 1));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    rd_d            = rd_q;
    is_div_d        = is_div_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    stall_o         = 1'b0;
    md_start_mult_o = 1'b0;
    md_start_div_o  = 1'b0;
    wb_valid_o      = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall_o = req_valid_i;
        if (req_valid_i) begin
          op_a_d   = req_operand_a_i;
          op_b_d   = req_operand_b_i;
          rd_d     = req_rd_i;
          is_div_d = req_is_div_i;
          state_d  = StStart;
        end
      end
      StStart: begin
        stall_o         = 1'b1;
        md_start_div_o  = is_div_q;
        md_start_mult_o = ~is_div_q;
        cnt_d           = '0;
        state_d         = StRun;
      end
      StRun: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // A result arriving on the timeout cycle still takes priority.
        if (md_ready_i) begin
          if (md_exception_i) begin
            wb_rd_d   = StatusReg;
            wb_data_d = exc_code;
            state_d   = StWb;
          end else if (rd_q == 5'd0) begin
            stall_o = 1'b0;
            state_d = StIdle;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = md_result_i;
            state_d   = StWb;
          end
        end else if (timed_out) begin
          wb_rd_d   = StatusReg;
          wb_data_d = exc_code;
          state_d   = StWb;
        end
      end
      StWb: begin
        wb_valid_o = 1'b1;
        stall_o    = ~wb_grant_i;
        if (wb_grant_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign md_operand_a_o = op_a_q;
  assign md_operand_b_o = op_b_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: mult/div completion, exception, rd=0 drop,
// delayed grant, watchdog timeout and mid-operation reset.
module tb_multdiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_is_div;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        start_mult, start_div;
  logic [31:0] md_a, md_b;
  logic        md_ready, md_exception;
  logic [31:0] md_result;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_grant, busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_mult_starts = 0;
  int n_div_starts = 0;
  int n_writes = 0;
  int n_r3_writes = 0;
  int snap;

  always #5 clk = ~clk;

  multdiv_sequencer dut (
    .clock_i         (clk),
    .reset_i         (reset),
    .req_valid_i     (req_valid),
    .req_is_div_i    (req_is_div),
    .req_operand_a_i (req_a),
    .req_operand_b_i (req_b),
    .req_rd_i        (req_rd),
    .md_start_mult_o (start_mult),
    .md_start_div_o  (start_div),
    .md_operand_a_o  (md_a),
    .md_operand_b_o  (md_b),
    .md_ready_i      (md_ready),
    .md_exception_i  (md_exception),
    .md_result_i     (md_result),
    .stall_o         (stall),
    .wb_valid_o      (wb_valid),
    .wb_rd_o         (wb_rd),
    .wb_data_o       (wb_data),
    .wb_grant_i      (wb_grant),
    .busy_o          (busy)
  );

  always @(posedge clk) begin
    if (start_mult) n_mult_starts <= n_mult_starts + 1;
    if (start_div)  n_div_starts  <= n_div_starts + 1;
    if (wb_valid && wb_grant) n_writes <= n_writes + 1;
    if (wb_valid && wb_grant && wb_rd == 5'd3) n_r3_writes <= n_r3_writes + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave 1 time unit for inputs to be driven before settle().
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic accept(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    req_valid  = 1'b1;
    req_is_div = is_div;
    req_a      = a;
    req_b      = b;
    req_rd     = rd;
    settle();
    chk("accept_stall", {31'b0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_a     = 32'hdead_beef;
    req_b     = 32'hcafe_f00d;
    req_rd    = 5'd31;
    settle();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_is_div = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = '0; wb_grant = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_start", {30'b0, start_mult, start_div}, 32'd0);
    chk("rst_op_a", md_a, 32'd0);

    // Mult 7x6 into r5, ready on the 32nd RUN cycle.
    tick();
    accept(1'b0, 32'd7, 32'd6, 5'd5);
    chk("m_start_mult", {31'b0, start_mult}, 32'd1);
    chk("m_start_div", {31'b0, start_div}, 32'd0);
    chk("m_op_a", md_a, 32'd7);
    chk("m_op_b", md_b, 32'd6);
    chk("m_start_stall", {31'b0, stall}, 32'd1);
    tick(); settle();
    for (int i = 0; i < 31; i++) begin
      chk("m_run_stall", {31'b0, stall}, 32'd1);
      tick(); settle();
    end
    md_ready = 1'b1; md_result = 32'd42;
    settle();
    chk("m_ready_stall", {31'b0, stall}, 32'd1);
    chk("m_ready_wbv", {31'b0, wb_valid}, 32'd0);
    tick();
    md_ready = 1'b0; md_result = '0; wb_grant = 1'b1;
    settle();
    chk("m_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("m_wb_rd", {27'b0, wb_rd}, 32'd5);
    chk("m_wb_data", wb_data, 32'd42);
    chk("m_wb_stall", {31'b0, stall}, 32'd0);
    tick();
    wb_grant = 1'b0;
    settle();
    chk("m_done_busy", {31'b0, busy}, 32'd0);
    chk("m_done_wbv", {31'b0, wb_valid}, 32'd0);
    chk("m_one_pulse", n_mult_starts, 32'd1);
    chk("m_op_a_hold", md_a, 32'd7);

    // Div 100/0 into r3 with exception: status code to r30.
    accept(1'b1, 32'd100, 32'd0, 5'd3);
    chk("dz_start_div", {31'b0, start_div}, 32'd1);
    chk("dz_start_mult", {31'b0, start_mult}, 32'd0);
    tick(); tick(); tick(); tick();
    md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h1234;
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    settle();
    chk("dz_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("dz_wb_rd", {27'b0, wb_rd}, 32'd30);
    chk("dz_wb_data", wb_data, 32'd5);
    chk("dz_stall", {31'b0, stall}, 32'd1);
    wb_grant = 1'b1;
    tick();
    wb_grant = 1'b0;
    settle();
    chk("dz_busy", {31'b0, busy}, 32'd0);
    chk("dz_no_r3", n_r3_writes, 32'd0);

    // Mult into r0: result dropped, no write.
    snap = n_writes;
    accept(1'b0, 32'd3, 32'd6, 5'd0);
    tick(); tick();
    md_ready = 1'b1; md_result = 32'h12;
    settle();
    chk("z_ready_stall", {31'b0, stall}, 32'd0);
    chk("z_ready_wbv", {31'b0, wb_valid}, 32'd0);
    tick();
    md_ready = 1'b0;
    settle();
    chk("z_idle_busy", {31'b0, busy}, 32'd0);
    chk("z_idle_wbv", {31'b0, wb_valid}, 32'd0);
    chk("z_idle_stall", {31'b0, stall}, 32'd0);
    chk("z_no_write", n_writes, snap);

    // Div 9/3 into r7 with grant withheld for 3 cycles.
    accept(1'b1, 32'd9, 32'd3, 5'd7);
    tick(); tick(); tick();
    md_ready = 1'b1; md_result = 32'd3;
    tick();
    md_ready = 1'b0; md_result = 32'hffff_ffff;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("g_wait_wbv", {31'b0, wb_valid}, 32'd1);
      chk("g_wait_data", wb_data, 32'd3);
      chk("g_wait_rd", {27'b0, wb_rd}, 32'd7);
      chk("g_wait_stall", {31'b0, stall}, 32'd1);
      tick(); settle();
    end
    wb_grant = 1'b1;
    settle();
    chk("g_grant_wbv", {31'b0, wb_valid}, 32'd1);
    chk("g_grant_data", wb_data, 32'd3);
    chk("g_grant_stall", {31'b0, stall}, 32'd0);
    tick();
    wb_grant = 1'b0;
    settle();
    chk("g_done_busy", {31'b0, busy}, 32'd0);

    // Mult that never completes: watchdog after 40 RUN cycles.
    accept(1'b0, 32'd11, 32'd13, 5'd9);
    tick(); settle();
    for (int i = 0; i < 40; i++) begin
      chk("t_run_wbv", {31'b0, wb_valid}, 32'd0);
      chk("t_run_busy", {31'b0, busy}, 32'd1);
      tick(); settle();
    end
    chk("t_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("t_wb_rd", {27'b0, wb_rd}, 32'd30);
    chk("t_wb_data", wb_data, 32'd4);
    wb_grant = 1'b1;
    tick();
    wb_grant = 1'b0;
    settle();
    chk("t_done_busy", {31'b0, busy}, 32'd0);

    // Reset mid-RUN aborts with no writeback.
    snap = n_writes;
    accept(1'b1, 32'd50, 32'd5, 5'd12);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("r_busy", {31'b0, busy}, 32'd0);
    chk("r_stall", {31'b0, stall}, 32'd0);
    chk("r_wbv", {31'b0, wb_valid}, 32'd0);
    chk("r_start", {30'b0, start_mult, start_div}, 32'd0);
    md_ready = 1'b1; md_result = 32'd10; wb_grant = 1'b1;
    tick();
    md_ready = 1'b0; wb_grant = 1'b0;
    settle();
    chk("r_late_wbv", {31'b0, wb_valid}, 32'd0);
    chk("r_late_busy", {31'b0, busy}, 32'd0);
    chk("r_no_write", n_writes, snap);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
